// File: rtl/inst_queue_pkg.sv
// +--------------------------------------------------------------------------+
// | inst_queue_pkg : shared constants and entry layout for the inst queue    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

package inst_queue_pkg;

  localparam int IQ_DEPTH   = 8;
  localparam int IQ_ENTRY_W = 65;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/iq_ram.sv
// +--------------------------------------------------------------------------+
// | iq_ram   : DEPTH x W register array, one write port, async read port     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module iq_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 65
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// +--------------------------------------------------------------------------+
// | inst_queue : fetch-side instruction FIFO, flushed on redirect            |
// |              Optional macro IQ_BYPASS_EN: empty-queue comb pass-through  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        in_adel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  output logic [AW:0] count
);

  localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_written;

  logic        w_empty;
  logic        w_full;
  logic        w_clear;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  iq_entry_t   w_wdata;
  iq_entry_t   w_rdata;
  iq_entry_t   w_out;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_clear  = rst | flush;
  assign in_ready = !w_full;

`ifdef IQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle never enters storage.
  assign w_push = in_valid && in_ready && !w_clear && !(w_bypass && out_ready);
  assign w_pop  = !w_empty && out_ready && !w_clear;

  assign w_wdata = '{adel: in_adel, pc: in_pc, inst: in_inst};

  iq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (IQ_ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Masks the uninitialised array until something has been stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_written <= 1'b0;
    end else if (w_push) begin
      r_written <= 1'b1;
    end
  end

  always_comb begin
    w_out = '0;
    if (w_bypass) begin
      w_out = w_wdata;
    end else if (r_written) begin
      w_out = w_rdata;
    end
  end

  assign out_valid = !w_empty || w_bypass;
  assign out_pc    = w_out.pc;
  assign out_inst  = w_out.inst;
  assign out_adel  = w_out.adel;
  assign count     = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// +--------------------------------------------------------------------------+
// | tb_inst_queue : randomized self-checking bench with a queue-based model  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_inst_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_adel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic        e_valid, e_ready, e_adel;
  logic [31:0] e_pc, e_inst;
  logic [3:0]  e_count;

  inst_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_adel   (in_adel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_adel  (out_adel),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: a list of entries in program order.
  task automatic model_eval();
    e_ready = (q.size() < DEPTH);
    e_count = 4'(q.size());
    e_valid = 1'b0;
    e_pc    = '0;
    e_inst  = '0;
    e_adel  = 1'b0;
    if (q.size() > 0) begin
      e_valid = 1'b1;
      e_pc    = q[0].pc;
      e_inst  = q[0].inst;
      e_adel  = q[0].adel;
    end
`ifdef IQ_BYPASS_EN
    else if (in_valid && !flush) begin
      e_valid = 1'b1;
      e_pc    = in_pc;
      e_inst  = in_inst;
      e_adel  = in_adel;
    end
`endif
  endtask

  task automatic model_step();
    bit   byp;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      byp = 1'b0;
`ifdef IQ_BYPASS_EN
      byp = (q.size() == 0) && in_valid && out_ready;
`endif
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH) && !byp;
      e = '{adel: in_adel, pc: in_pc, inst: in_inst};
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic adel, input logic rdy, input logic fl, input logic rs);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_adel   = adel;
    out_ready = rdy;
    flush     = fl;
    rst       = rs;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d, want 0/1/0", out_valid, in_ready, count);
    end
    checks++;
    if ({out_adel, out_pc, out_inst} !== 65'd0) begin
      errors++;
      $display("FAIL reset_fields: got pc=%h inst=%h adel=%b, want zeros", out_pc, out_inst, out_adel);
    end
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'hBFC00000, 32'h24080001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000 || out_inst !== 32'h24080001 || out_adel !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_push: got v=%b pc=%h inst=%h adel=%b cnt=%0d, want 1 bfc00000 24080001 0 1",
               out_valid, out_pc, out_inst, out_adel, count);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_fill_and_full_pop();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 32'h1000 + 32'(4 * k), 32'hA000 + 32'(k), k[0], 1'b0, 1'b0, 1'b0); tick();
    end
    drive(1'b1, 32'h1020, 32'hA008, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL full: got ready=%b count=%0d, want 0 and 8", in_ready, count);
    end
    tick();
    drive(1'b1, 32'h1024, 32'hA009, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || out_pc !== 32'h1000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ninth_push: got count=%0d head=%h ready=%b, want 8 00001000 0", count, out_pc, in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd7 || in_ready !== 1'b1 || out_pc !== 32'h1004 || out_adel !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: got count=%0d ready=%b head=%h adel=%b, want 7 1 00001004 1",
               count, in_ready, out_pc, out_adel);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_stream();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic rdy;
    while (popped < 20 && cyc < 200) begin
      rdy = (cyc % 2 == 0);
      drive(pushed < 20, 32'h80000000 + 32'(4 * pushed), 32'(pushed * 3 + 7), 1'b0, rdy, 1'b0, 1'b0);
      checks++;
      if (count !== e_count || out_valid !== e_valid) begin
        errors++;
        $display("FAIL stream_ctrl cyc=%0d: got count=%0d valid=%b, want %0d %b", cyc, count, out_valid, e_count, e_valid);
      end
      if (out_valid && rdy) begin
        checks++;
        if (out_pc !== 32'h80000000 + 32'(4 * popped)) begin
          errors++;
          $display("FAIL stream_order #%0d: got pc=%h, want %h", popped, out_pc, 32'h80000000 + 32'(4 * popped));
        end
        popped++;
      end
      if (pushed < 20 && in_ready) pushed++;
      tick();
      cyc++;
    end
    checks++;
    if (popped != 20) begin
      errors++;
      $display("FAIL stream_timeout: got %0d entries out, want 20", popped);
    end
  endtask

  task automatic test_flush();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h4000 + 32'(4 * k), 32'(k), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    drive(1'b1, 32'hDEAD0000, 32'h0BADF00D, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL flush_pre: got count=%0d, want 5", count);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_post: got count=%0d valid=%b, want 0 0", count, out_valid);
    end
    tick();
    drive(1'b1, 32'h000000A0, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h000000A0 || count !== 4'd1) begin
      errors++;
      $display("FAIL flush_after: got v=%b pc=%h cnt=%0d, want 1 000000a0 1", out_valid, out_pc, count);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'hBFC00010, 32'h3C1D8000, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef IQ_BYPASS_EN
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hBFC00010) begin
      errors++;
      $display("FAIL bypass_same: got v=%b pc=%h, want 1 bfc00010", out_valid, out_pc);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after: got count=%0d v=%b, want 0 0", count, out_valid);
    end
`else
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass_same: got v=%b, want 0", out_valid);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b1 || out_pc !== 32'hBFC00010) begin
      errors++;
      $display("FAIL no_bypass_after: got count=%0d v=%b pc=%h, want 1 1 bfc00010", count, out_valid, out_pc);
    end
`endif
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pc = $urandom;
      drive(($urandom % 4) != 0, pc, $urandom, 1'($urandom % 2), ($urandom % 3) != 0,
            ($urandom % 40) == 0, ($urandom % 97) == 0);
      checks++;
      if (out_valid !== e_valid || count !== e_count || in_ready !== e_ready ||
          (e_valid && {out_adel, out_pc, out_inst} !== {e_adel, e_pc, e_inst})) begin
        errors++;
        $display("FAIL random cyc=%0d: got v=%b cnt=%0d rdy=%b pc=%h inst=%h adel=%b want v=%b cnt=%0d rdy=%b pc=%h inst=%h adel=%b",
                 cyc, out_valid, count, in_ready, out_pc, out_inst, out_adel,
                 e_valid, e_count, e_ready, e_pc, e_inst, e_adel);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_and_full_pop();
    test_stream();
    test_flush();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
